adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
- Sequences the 4-lane ADC packer (4 x 14-bit samples per 64-bit word) into triggered capture windows.
- Arms on command and waits for a hardware or software trigger, then applies a programmable hold-off.
- Forwards exactly i_len packed words downstream over valid/ready, with start-of-frame and end-of-frame flags.
- Sits between the packer and the readout FIFO/DMA. Drives the packer enable and reports status to the register block.

Parameters:
- SAMPLE_W, 14, ADC sample width.
- WORD_W, 64, packed word width.
- LEN_W, 16, width of the capture length and word counters.
- HOLD_W, 8, width of the hold-off counter.
- TIMEOUT, 1000000, ARMED timeout in cycles (used only with TRIG_TIMEOUT_EN).

Ports:
- i_62clk  in  1  sole clock.
- i_nreset  in  1  asynchronous active-low reset.
- i_arm  in  1  one-cycle pulse; latches i_len and i_holdoff and arms the controller.
- i_abort  in  1  one-cycle pulse; cancels any activity.
- i_trig  in  1  asynchronous external trigger, rising-edge sensitive.
- i_soft_trig  in  1  synchronous one-cycle software trigger.
- i_len  in  LEN_W  words per capture.
- i_holdoff  in  HOLD_W  cycles between trigger detection and capture start.
- i_word_valid  in  1  packer word strobe.
- i_word  in  WORD_W  packed word from the packer.
- o_pack_en  out  1  packer run enable; packer held in reset when low.
- o_word  out  WORD_W  registered output word.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- o_sof  out  1  qualifies the first word of a frame.
- o_eof  out  1  qualifies the last word of a frame.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when a frame completes.
- o_overflow  out  1  sticky flag: a word was dropped.
- o_words  out  LEN_W  words captured so far in the current frame.

Behaviour:
- Reset: clock i_62clk; reset asynchronous, active-low on i_nreset. All outputs are 0, state is IDLE, and the sync flops are 0.
- Trigger path:
  - i_trig passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge becomes an internal trig pulse 3 cycles after the input rises.
  - The internal trigger is (trig pulse OR i_soft_trig).
- State IDLE:
  - o_pack_en = 0.
  - On i_arm with i_len != 0: latch len and holdoff, clear o_overflow and o_words, go to ARMED.
  - i_arm with i_len == 0 is ignored.
- State ARMED:
  - o_pack_en = 1.
  - On trigger: go to HOLDOFF if holdoff != 0, else go to CAPTURE.
  - Triggers arriving in any other state are ignored.
- State HOLDOFF: a down-counter loaded with holdoff. When it reaches 1, go to CAPTURE, so capture starts exactly holdoff cycles after the trigger.
- State CAPTURE, on each i_word_valid:
  - Output register empty or draining (!o_valid or i_ready): load o_word.
    - o_valid = 1.
    - o_sof = 1 if o_words == 0.
    - o_eof = 1 if o_words == len-1.
  - Output register full and stalled: drop the word and set o_overflow. The dropped word still counts toward len, so the window is fixed in time. If it was the last word, o_eof is lost and DONE is still reached.
  - Every accepted or dropped word increments o_words. When o_words reaches len, go to DRAIN.
- State DRAIN:
  - o_pack_en = 0.
  - Wait until !o_valid, or until o_valid && i_ready clears the register.
  - Then pulse o_done and go to IDLE.
- Output handshake: o_valid && i_ready clears o_valid. A simultaneous clear and new load yields back-to-back words. o_sof and o_eof are meaningful only while o_valid is high.
- Abort: i_abort in any state leads to IDLE on the next edge with o_valid = 0 and o_pack_en = 0. o_overflow and o_words are held, and no o_done pulse is issued. Abort has priority over arm and trigger in the same cycle.
- i_arm while busy is ignored.
- Words received outside CAPTURE are discarded without flagging.

Optional Feature:
TRIG_TIMEOUT_EN:
- Defined:
  - A counter runs while in ARMED.
  - After TIMEOUT cycles with no trigger, the controller returns to IDLE.
  - An extra output, o_timeout, pulses for one cycle on that transition.
- Undefined: there is no counter and no o_timeout port; ARMED waits indefinitely.

Decomposition:
- Package adc_ctrl_pkg:
  - state enum: IDLE, ARMED, HOLDOFF, CAPTURE, DRAIN.
  - constants: SAMPLE_W, WORD_W, LANES = 4.
  - typedef for the packed word.
- One sub-module, adc_trig_detect: 2-flop synchronizer plus rising-edge pulse.

Test Plan:
- Basic frame: arm with len=3, holdoff=0, soft trigger, i_ready=1, words every 4 cycles → 3 words out; sof on word 0, eof on word 2; o_done 1 cycle after the last handshake; o_overflow = 0.
- External trigger with hold-off: arm with holdoff=5, raise i_trig → CAPTURE entered exactly 3+5 cycles after the rise; words before that are not forwarded.
- Backpressure: len=4, i_ready=0 throughout capture → first word held, words 2-4 dropped, o_overflow = 1, o_words = 4, DRAIN held until i_ready goes high, then o_done.
- Abort mid-capture after 2 of 5 words → IDLE next cycle, o_valid = 0, o_pack_en = 0, no o_done; a re-arm clears o_overflow.
- Edge cases: i_arm with len=0 → stays IDLE; i_trig held high across arm → no trigger until the next rising edge; async reset mid-CAPTURE → all outputs 0 immediately.
- With TRIG_TIMEOUT_EN and TIMEOUT=20: arm, no trigger → o_timeout pulses at cycle 20 and the controller returns to IDLE.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adc_ctrl_pkg
//
// Shared types and constants for the ADC capture controller.
//   - adc_state_e : capture sequencer states.
//   - SAMPLE_W, LANES, WORD_W : packer geometry (4 x 14-bit samples in 64 bits).
//   - adc_word_t  : packed word as produced by the 4-lane packer.
// ----------------------------------------------------------------------------
package adc_ctrl_pkg;

    localparam int SAMPLE_W = 14;
    localparam int LANES    = 4;
    localparam int WORD_W   = 64;

    // Bits left over above the four samples in each packed word.
    localparam int PAD_W    = WORD_W - LANES * SAMPLE_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HOLDOFF = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } adc_state_e;

    // Lane 0 occupies the least significant sample slot.
    typedef struct packed {
        logic [PAD_W-1:0]                 pad;
        logic [LANES-1:0][SAMPLE_W-1:0]   lane;
    } adc_word_t;

endpackage : adc_ctrl_pkg

// File: rtl/adc_trig_detect.sv
// ----------------------------------------------------------------------------
// adc_trig_detect
//
// Brings the asynchronous external trigger into the clock domain and turns
// each rising edge into a single-cycle pulse.
//
// Ports:
//   clk_i    : clock.
//   rst_ni   : asynchronous active-low reset; clears all sync flops.
//   trig_i   : asynchronous trigger input, rising-edge sensitive.
//   pulse_o  : one-cycle pulse, high during the third cycle after trig_i rises,
//              so the consuming logic acts on it at the third clock edge.
// ----------------------------------------------------------------------------
module adc_trig_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync2_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync2_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so each stage samples the value
            // the previous stage held before this edge; blocking would
            // collapse the chain into a single flop.
            sync1_q      <= trig_i;
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
        end
    end

    // Both operands come straight from flops, so the pulse is glitch-free.
    assign pulse_o = sync2_q & ~sync2_prev_q;

endmodule : adc_trig_detect

// File: rtl/adc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// adc_capture_ctrl
//
// Sequences the 4-lane ADC packer into triggered capture windows. The block
// is armed by command, waits for a hardware or software trigger, waits a
// programmable hold-off, then forwards exactly len packed words downstream
// over valid/ready with start- and end-of-frame flags.
//
// Optional feature macro: TRIG_TIMEOUT_EN
//   When defined, ARMED gives up after TIMEOUT cycles without a trigger,
//   returns to IDLE and pulses o_timeout. When undefined there is no counter,
//   no TIMEOUT parameter and no o_timeout port.
//
// Ports:
//   i_62clk       : clock.
//   i_nreset      : asynchronous active-low reset.
//   i_arm         : one-cycle pulse; latches i_len/i_holdoff and arms (IDLE only).
//   i_abort       : one-cycle pulse; returns to IDLE from any state.
//   i_trig        : asynchronous external trigger, rising-edge sensitive.
//   i_soft_trig   : synchronous one-cycle software trigger.
//   i_len         : words per capture (0 ignores the arm).
//   i_holdoff     : cycles between trigger and capture start.
//   i_word_valid  : packer word strobe.
//   i_word        : packed word from the packer.
//   o_pack_en     : packer run enable.
//   o_word        : registered output word.
//   o_valid       : output valid.
//   i_ready       : downstream ready.
//   o_sof / o_eof : first / last word of the frame (qualified by o_valid).
//   o_busy        : high in any state other than IDLE.
//   o_done        : one-cycle pulse when a frame completes.
//   o_overflow    : sticky; a word was dropped because the output stalled.
//   o_words       : words captured (accepted or dropped) in the current frame.
//   o_timeout     : (TRIG_TIMEOUT_EN only) one-cycle pulse on ARMED timeout.
// ----------------------------------------------------------------------------
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int HOLD_W = 8
`ifdef TRIG_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1000000
`endif
) (
    input  logic              i_62clk,
    input  logic              i_nreset,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_trig,
    input  logic              i_soft_trig,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [HOLD_W-1:0] i_holdoff,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_pack_en,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [LEN_W-1:0]  o_words
`ifdef TRIG_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    // ------------------------------------------------------------------
    // Trigger path
    // ------------------------------------------------------------------
    logic trig_pulse;
    logic trig;

    adc_trig_detect u_trig_detect (
        .clk_i   (i_62clk),
        .rst_ni  (i_nreset),
        .trig_i  (i_trig),
        .pulse_o (trig_pulse)
    );

    assign trig = trig_pulse | i_soft_trig;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    adc_state_e        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [LEN_W-1:0]  words_q;
    adc_word_t         word_q;
    logic              valid_q;
    logic              sof_q;
    logic              eof_q;
    logic              busy_q;
    logic              pack_en_q;
    logic              done_q;
    logic              overflow_q;

`ifdef TRIG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;
`endif

    // The word currently arriving is the last one of the window.
    logic last_word;
    assign last_word = (words_q == len_q - LEN_W'(1));

    always_ff @(posedge i_62clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            hold_cnt_q <= '0;
            words_q    <= '0;
            // NOTE: the output data register is reset along with the control
            // state so o_word reads 0 straight out of reset.
            word_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            busy_q     <= 1'b0;
            pack_en_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // A handshake empties the output register; a load later in this
            // block overrides it, giving back-to-back words.
            if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end

            if (i_abort) begin
                // Abort wins over arm and trigger; frame status is kept for
                // software to inspect, and no done pulse is issued.
                state_q   <= IDLE;
                valid_q   <= 1'b0;
                pack_en_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (i_arm && (i_len != '0)) begin
                            len_q      <= i_len;
                            hold_cnt_q <= i_holdoff;
                            overflow_q <= 1'b0;
                            words_q    <= '0;
                            state_q    <= ARMED;
                            pack_en_q  <= 1'b1;
                            busy_q     <= 1'b1;
`ifdef TRIG_TIMEOUT_EN
                            tmo_cnt_q  <= '0;
`endif
                        end
                    end

                    ARMED: begin
                        if (trig) begin
                            // hold_cnt_q already holds the latched hold-off.
                            state_q <= (hold_cnt_q != '0) ? HOLDOFF : CAPTURE;
                        end
`ifdef TRIG_TIMEOUT_EN
                        else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                            state_q   <= IDLE;
                            pack_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
`endif
                    end

                    HOLDOFF: begin
                        // Leaving on the count of 1 makes the capture start
                        // exactly hold-off cycles after the trigger edge.
                        if (hold_cnt_q == HOLD_W'(1)) begin
                            state_q <= CAPTURE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                        end
                    end

                    CAPTURE: begin
                        if (i_word_valid) begin
                            if (!valid_q || i_ready) begin
                                word_q  <= adc_word_t'(i_word);
                                valid_q <= 1'b1;
                                sof_q   <= (words_q == '0);
                                eof_q   <= last_word;
                            end else begin
                                // Stalled: drop the word but still count it,
                                // keeping the capture window fixed in time.
                                overflow_q <= 1'b1;
                            end
                            words_q <= words_q + LEN_W'(1);
                            if (last_word) begin
                                state_q   <= DRAIN;
                                pack_en_q <= 1'b0;
                            end
                        end
                    end

                    DRAIN: begin
                        if (!valid_q || i_ready) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end

                    default: begin
                        state_q   <= IDLE;
                        pack_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pack_en  = pack_en_q;
    assign o_word     = word_q;
    assign o_valid    = valid_q;
    assign o_sof      = sof_q;
    assign o_eof      = eof_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_words    = words_q;
`ifdef TRIG_TIMEOUT_EN
    assign o_timeout  = timeout_q;
`endif

endmodule : adc_capture_ctrl
